// File: rtl/al_ctrl_pkg.sv
// Shared definitions for the alarm-clock control slice: mode encoding,
// time-field width/limit and the wrapping field step used by the editor.
package al_ctrl_pkg;

  localparam int TIME_W = 7;
  localparam logic [TIME_W-1:0] FIELD_MAX = TIME_W'(59);

  typedef enum logic [1:0] {
    MODE_VIEW = 2'd0,
    MODE_SETC = 2'd1,
    MODE_SETA = 2'd2
  } mode_e;

  localparam int NUM_BTN  = 7;
  localparam int B_VIEW   = 0;
  localparam int B_SETC   = 1;
  localparam int B_SETA   = 2;
  localparam int B_SECMIN = 3;
  localparam int B_INC    = 4;
  localparam int B_DEC    = 5;
  localparam int B_ACT    = 6;

  // Out-of-range values are pulled back into 0..59 rather than stepping further away.
  function automatic logic [TIME_W-1:0] field_step(input logic [TIME_W-1:0] v,
                                                   input logic up);
    if (up) return (v >= FIELD_MAX) ? '0 : v + TIME_W'(1);
    else    return (v == '0 || v > FIELD_MAX) ? FIELD_MAX : v - TIME_W'(1);
  endfunction

endpackage

// File: rtl/al_debounce.sv
// One button: 2-flop synchronizer, stability counter, and a one-cycle
// pulse on the accepted 0->1 transition.
module al_debounce #(
  parameter int DEB_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter only runs while the sample disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) level_d = sync2_q;
      else                              cnt_d   = cnt_q + CW'(1);
    end
  end

  assign press = level_d & ~level_q;

endmodule

// File: rtl/al_mode_ctrl.sv
// Alarm-clock sequencer: debounced buttons, VIEW/SETC/SETA mode FSM,
// edit registers, stored alarm time and ring control.
module al_mode_ctrl
  import al_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 20000,
  parameter int RING_SEC   = 30
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              BTN_VIEW,
  input  logic              BTN_SETC,
  input  logic              BTN_SETA,
  input  logic              BTN_SECMIN,
  input  logic              BTN_INC,
  input  logic              BTN_DEC,
  input  logic              BTN_ACTIVEA,
  input  logic              TICK_1S,
  input  logic [TIME_W-1:0] CUR_MIN,
  input  logic [TIME_W-1:0] CUR_SEC,
  output logic [1:0]        MODE,
  output logic [TIME_W-1:0] EDIT_MIN,
  output logic [TIME_W-1:0] EDIT_SEC,
  output logic              SEL_SEC,
  output logic              LOAD_CUR,
  output logic [TIME_W-1:0] ALARM_MIN,
  output logic [TIME_W-1:0] ALARM_SEC,
  output logic              ALARM_EN,
  output logic              RINGING,
  output logic              LED_VIEW,
  output logic              LED_SETC,
  output logic              LED_SETA,
  output logic              LED_ACTIVEA
);

  localparam int RW = $clog2(RING_SEC + 1);

  logic [NUM_BTN-1:0] btn_raw, press;

  assign btn_raw = {BTN_ACTIVEA, BTN_DEC, BTN_INC, BTN_SECMIN, BTN_SETA, BTN_SETC, BTN_VIEW};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    al_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (CLK),
      .rst_n   (RST_N),
      .btn_raw (btn_raw[i]),
      .press   (press[i])
    );
  end

  logic p_view, p_setc, p_seta, p_secmin, p_inc, p_dec, p_act;

  assign p_view   = press[B_VIEW];
  assign p_setc   = press[B_SETC] & ~p_view;
  assign p_seta   = press[B_SETA] & ~p_view & ~press[B_SETC];
  assign p_secmin = press[B_SECMIN];
  assign p_inc    = press[B_INC];
  assign p_dec    = press[B_DEC];
  assign p_act    = press[B_ACT];

  // state | meaning
  // VIEW  | showing time, edit buttons ignored
  // SETC  | editing current time, commit loads timekeeper
  // SETA  | editing alarm time, commit writes alarm registers
  mode_e mode_q, mode_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) mode_q <= MODE_VIEW;
    else        mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (p_view)      mode_d = MODE_VIEW;
    else if (p_setc) mode_d = (mode_q == MODE_SETC) ? MODE_VIEW : MODE_SETC;
    else if (p_seta) mode_d = (mode_q == MODE_SETA) ? MODE_VIEW : MODE_SETA;
  end

  always_comb begin
    MODE     = mode_q;
    LED_VIEW = (mode_q == MODE_VIEW);
    LED_SETC = (mode_q == MODE_SETC);
    LED_SETA = (mode_q == MODE_SETA);
  end

  logic [TIME_W-1:0] edit_min_q, edit_min_d, edit_sec_q, edit_sec_d;
  logic [TIME_W-1:0] alarm_min_q, alarm_min_d, alarm_sec_q, alarm_sec_d;
  logic              sel_sec_q, sel_sec_d, load_cur_q, load_cur_d;
  logic              alarm_en_q, alarm_en_d, ringing_q, ringing_d, tick_q;
  logic [RW-1:0]     ring_cnt_q, ring_cnt_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      edit_min_q  <= '0;
      edit_sec_q  <= '0;
      sel_sec_q   <= 1'b1;
      load_cur_q  <= 1'b0;
      alarm_min_q <= '0;
      alarm_sec_q <= '0;
      alarm_en_q  <= 1'b0;
      ringing_q   <= 1'b0;
      ring_cnt_q  <= '0;
      tick_q      <= 1'b0;
    end else begin
      edit_min_q  <= edit_min_d;
      edit_sec_q  <= edit_sec_d;
      sel_sec_q   <= sel_sec_d;
      load_cur_q  <= load_cur_d;
      alarm_min_q <= alarm_min_d;
      alarm_sec_q <= alarm_sec_d;
      alarm_en_q  <= alarm_en_d;
      ringing_q   <= ringing_d;
      ring_cnt_q  <= ring_cnt_d;
      tick_q      <= TICK_1S;
    end
  end

  // Mode presses own the edit registers for the cycle; field edits only apply otherwise.
  always_comb begin
    edit_min_d  = edit_min_q;
    edit_sec_d  = edit_sec_q;
    sel_sec_d   = sel_sec_q;
    alarm_min_d = alarm_min_q;
    alarm_sec_d = alarm_sec_q;
    load_cur_d  = 1'b0;
    if (p_setc) begin
      if (mode_q == MODE_SETC) begin
        load_cur_d = 1'b1;
      end else begin
        edit_min_d = CUR_MIN;
        edit_sec_d = CUR_SEC;
        sel_sec_d  = 1'b1;
      end
    end else if (p_seta) begin
      if (mode_q == MODE_SETA) begin
        alarm_min_d = edit_min_q;
        alarm_sec_d = edit_sec_q;
      end else begin
        edit_min_d = alarm_min_q;
        edit_sec_d = alarm_sec_q;
        sel_sec_d  = 1'b1;
      end
    end else if (!p_view && mode_q != MODE_VIEW) begin
      if (p_inc ^ p_dec) begin
        if (sel_sec_q) edit_sec_d = field_step(edit_sec_q, p_inc);
        else           edit_min_d = field_step(edit_min_q, p_inc);
      end
      if (p_secmin) sel_sec_d = ~sel_sec_q;
    end
  end

  // CUR_* has advanced by the cycle after the tick, so match and count on the delayed tick.
  always_comb begin
    alarm_en_d = alarm_en_q;
    ringing_d  = ringing_q;
    ring_cnt_d = ring_cnt_q;
    if (tick_q && ringing_q) begin
      if (ring_cnt_q == RW'(RING_SEC - 1)) begin
        ringing_d  = 1'b0;
        ring_cnt_d = '0;
      end else begin
        ring_cnt_d = ring_cnt_q + RW'(1);
      end
    end
    if (tick_q && alarm_en_q && CUR_MIN == alarm_min_q && CUR_SEC == alarm_sec_q) begin
      ringing_d  = 1'b1;
      ring_cnt_d = '0;
    end
    if (p_act) begin
      if (ringing_q) ringing_d  = 1'b0;
      else           alarm_en_d = ~alarm_en_q;
    end
    if (p_view)      ringing_d = 1'b0;
    if (!alarm_en_d) ringing_d = 1'b0;
  end

  assign EDIT_MIN    = edit_min_q;
  assign EDIT_SEC    = edit_sec_q;
  assign SEL_SEC     = sel_sec_q;
  assign LOAD_CUR    = load_cur_q;
  assign ALARM_MIN   = alarm_min_q;
  assign ALARM_SEC   = alarm_sec_q;
  assign ALARM_EN    = alarm_en_q;
  assign RINGING     = ringing_q;
  assign LED_ACTIVEA = alarm_en_q;

endmodule

// File: tb/tb_al_mode_ctrl.sv
// Bench for al_mode_ctrl: directed scenarios plus random button/tick traffic
// checked against an event-level model of the controller.
module tb_al_mode_ctrl;

  localparam int DEB  = 4;
  localparam int RING = 3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [6:0] btn = '0;
  logic       TICK_1S = 1'b0;
  logic [6:0] CUR_MIN = '0, CUR_SEC = '0;

  logic [1:0] MODE;
  logic [6:0] EDIT_MIN, EDIT_SEC, ALARM_MIN, ALARM_SEC;
  logic       SEL_SEC, LOAD_CUR, ALARM_EN, RINGING;
  logic       LED_VIEW, LED_SETC, LED_SETA, LED_ACTIVEA;

  al_mode_ctrl #(.DEB_CYCLES(DEB), .RING_SEC(RING)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .BTN_VIEW(btn[0]), .BTN_SETC(btn[1]), .BTN_SETA(btn[2]), .BTN_SECMIN(btn[3]),
    .BTN_INC(btn[4]), .BTN_DEC(btn[5]), .BTN_ACTIVEA(btn[6]),
    .TICK_1S(TICK_1S), .CUR_MIN(CUR_MIN), .CUR_SEC(CUR_SEC),
    .MODE(MODE), .EDIT_MIN(EDIT_MIN), .EDIT_SEC(EDIT_SEC), .SEL_SEC(SEL_SEC),
    .LOAD_CUR(LOAD_CUR), .ALARM_MIN(ALARM_MIN), .ALARM_SEC(ALARM_SEC),
    .ALARM_EN(ALARM_EN), .RINGING(RINGING), .LED_VIEW(LED_VIEW), .LED_SETC(LED_SETC),
    .LED_SETA(LED_SETA), .LED_ACTIVEA(LED_ACTIVEA)
  );

  always #5 CLK = ~CLK;

  int vectors = 0, miscompares = 0;
  int load_cnt = 0;
  logic [6:0] load_min = '0, load_sec = '0;

  always @(negedge CLK) begin
    if (LOAD_CUR === 1'b1) begin
      load_cnt++;
      load_min = EDIT_MIN;
      load_sec = EDIT_SEC;
    end
  end

  // Model: mode 0/1/2, edit, selection, alarm, enable, ringing and seconds rung.
  int m_mode, m_emin, m_esec, m_amin, m_asec, m_rcnt;
  bit m_sel, m_en, m_ring;

  logic [36:0] dut_snap;
  assign dut_snap = {MODE, EDIT_MIN, EDIT_SEC, SEL_SEC, ALARM_MIN, ALARM_SEC,
                     ALARM_EN, RINGING, LED_VIEW, LED_SETC, LED_SETA, LED_ACTIVEA};

  function automatic logic [36:0] exp_snap();
    return {2'(m_mode), 7'(m_emin), 7'(m_esec), m_sel, 7'(m_amin), 7'(m_asec),
            m_en, m_ring, m_mode == 0, m_mode == 1, m_mode == 2, m_en};
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_emin = 0; m_esec = 0; m_sel = 1'b1;
    m_amin = 0; m_asec = 0; m_en = 1'b0; m_ring = 1'b0; m_rcnt = 0;
  endfunction

  // Bits: 0 VIEW, 1 SETC, 2 SETA, 3 SECMIN, 4 INC, 5 DEC, 6 ACTIVEA. Returns 1 on a time commit.
  function automatic bit model_press(input logic [6:0] m);
    bit ld, r0;
    int step;
    ld = 1'b0;
    r0 = m_ring;
    if (m[0]) begin
      m_mode = 0; m_ring = 1'b0;
    end else if (m[1]) begin
      if (m_mode == 1) begin m_mode = 0; ld = 1'b1; end
      else begin m_mode = 1; m_emin = int'(CUR_MIN); m_esec = int'(CUR_SEC); m_sel = 1'b1; end
    end else if (m[2]) begin
      if (m_mode == 2) begin m_mode = 0; m_amin = m_emin; m_asec = m_esec; end
      else begin m_mode = 2; m_emin = m_amin; m_esec = m_asec; m_sel = 1'b1; end
    end else if (m_mode != 0) begin
      if (m[4] != m[5]) begin
        step = m[4] ? 1 : 59;
        if (m_sel) m_esec = (m_esec + step) % 60;
        else       m_emin = (m_emin + step) % 60;
      end
      if (m[3]) m_sel = !m_sel;
    end
    if (m[6]) begin
      if (r0) m_ring = 1'b0;
      else begin m_en = !m_en; if (!m_en) m_ring = 1'b0; end
    end
    return ld;
  endfunction

  function automatic void model_tick();
    if (m_ring) begin
      m_rcnt++;
      if (m_rcnt >= RING) m_ring = 1'b0;
    end
    if (m_en && int'(CUR_MIN) == m_amin && int'(CUR_SEC) == m_asec) begin
      m_ring = 1'b1; m_rcnt = 0;
    end
  endfunction

  task automatic apply_reset();
    @(negedge CLK);
    RST_N = 1'b0; btn = '0; TICK_1S = 1'b0;
    repeat (3) @(negedge CLK);
    model_reset();
    RST_N = 1'b1;
  endtask

  // Holds the raw buttons for 'hold' cycles; an accepted press acts on the 6th edge.
  task automatic press(input logic [6:0] mask, input int hold);
    bit acc, ld;
    acc = (hold >= DEB);
    ld = 1'b0;
    @(negedge CLK);
    btn = mask;
    for (int k = 1; k <= hold + 8; k++) begin
      @(negedge CLK);
      if (k == 2 + DEB && acc) ld = model_press(mask);
      vectors++;
      if (LOAD_CUR !== (k == 2 + DEB && ld)) begin
        miscompares++;
        $display("FAIL load_cur k=%0d mask=%b: got %b want %b", k, mask, LOAD_CUR, (k == 2 + DEB && ld));
      end
      if (k == 1 + DEB || k == 2 + DEB || k == hold + 8) begin
        vectors++;
        if (dut_snap !== exp_snap()) begin
          miscompares++;
          $display("FAIL press_state k=%0d mask=%b hold=%0d: got %h want %h", k, mask, hold, dut_snap, exp_snap());
        end
      end
      if (k == hold) btn = '0;
    end
  endtask

  task automatic tick(input int mn, input int sc);
    @(negedge CLK);
    CUR_MIN = 7'(mn); CUR_SEC = 7'(sc); TICK_1S = 1'b1;
    @(negedge CLK);
    TICK_1S = 1'b0;
    vectors++;
    if (dut_snap !== exp_snap()) begin
      miscompares++;
      $display("FAIL tick_early %0d:%0d: got %h want %h", mn, sc, dut_snap, exp_snap());
    end
    @(negedge CLK);
    model_tick();
    vectors++;
    if (dut_snap !== exp_snap()) begin
      miscompares++;
      $display("FAIL tick_state %0d:%0d: got %h want %h", mn, sc, dut_snap, exp_snap());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({MODE, LED_VIEW, LED_SETC, LED_SETA, SEL_SEC, ALARM_EN, RINGING, LOAD_CUR} !== {2'd0, 3'b100, 4'b1000}) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want %b",
               {MODE, LED_VIEW, LED_SETC, LED_SETA, SEL_SEC, ALARM_EN, RINGING, LOAD_CUR}, {2'd0, 3'b100, 4'b1000});
    end
    vectors++;
    if (dut_snap !== exp_snap()) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", dut_snap, exp_snap());
    end
  endtask

  task automatic test_debounce();
    CUR_MIN = 7'd0; CUR_SEC = 7'd10;
    press(7'b0000010, 6);
    press(7'b0010000, 3);
    vectors++;
    if (EDIT_SEC !== 7'd10) begin
      miscompares++; $display("FAIL glitch_ignored: got %0d want 10", EDIT_SEC);
    end
    press(7'b0010000, 10);
    vectors++;
    if (EDIT_SEC !== 7'd11) begin
      miscompares++; $display("FAIL long_press_once: got %0d want 11", EDIT_SEC);
    end
    press(7'b0000001, 5);
  endtask

  task automatic test_set_current();
    int l0;
    CUR_MIN = 7'd12; CUR_SEC = 7'd58;
    l0 = load_cnt;
    press(7'b0000010, 5);
    press(7'b0010000, 5);
    vectors++;
    if ({EDIT_MIN, EDIT_SEC} !== {7'd12, 7'd59}) begin
      miscompares++; $display("FAIL setc_1259: got %0d:%0d want 12:59", EDIT_MIN, EDIT_SEC);
    end
    press(7'b0010000, 5);
    vectors++;
    if ({EDIT_MIN, EDIT_SEC} !== {7'd12, 7'd0}) begin
      miscompares++; $display("FAIL setc_1200: got %0d:%0d want 12:00", EDIT_MIN, EDIT_SEC);
    end
    press(7'b0001000, 5);
    press(7'b0100000, 5);
    vectors++;
    if ({EDIT_MIN, EDIT_SEC} !== {7'd11, 7'd0}) begin
      miscompares++; $display("FAIL setc_1100: got %0d:%0d want 11:00", EDIT_MIN, EDIT_SEC);
    end
    press(7'b0000010, 5);
    vectors++;
    if (load_cnt - l0 !== 1 || load_min !== 7'd11 || load_sec !== 7'd0 || MODE !== 2'd0) begin
      miscompares++;
      $display("FAIL setc_commit: got loads=%0d %0d:%0d mode=%0d want 1 11:0 0", load_cnt - l0, load_min, load_sec, MODE);
    end
  endtask

  task automatic test_wrap_cancel();
    int l0;
    apply_reset();
    l0 = load_cnt;
    press(7'b0000100, 5);
    press(7'b0100000, 5);
    vectors++;
    if (EDIT_SEC !== 7'd59) begin
      miscompares++; $display("FAIL dec_wrap: got %0d want 59", EDIT_SEC);
    end
    press(7'b0000001, 5);
    vectors++;
    if (ALARM_SEC !== 7'd0 || load_cnt !== l0 || MODE !== 2'd0) begin
      miscompares++;
      $display("FAIL view_cancel: got asec=%0d loads=%0d mode=%0d want 0 0 0", ALARM_SEC, load_cnt - l0, MODE);
    end
  endtask

  task automatic test_alarm_ring();
    apply_reset();
    press(7'b0000100, 5);
    for (int i = 0; i < 5; i++) press(7'b0010000, 4);
    press(7'b0000100, 5);
    press(7'b1000000, 5);
    vectors++;
    if ({ALARM_MIN, ALARM_SEC, ALARM_EN} !== {7'd0, 7'd5, 1'b1}) begin
      miscompares++; $display("FAIL alarm_stored: got %0d:%0d en=%b want 0:5 en=1", ALARM_MIN, ALARM_SEC, ALARM_EN);
    end
    tick(0, 3);
    tick(0, 4);
    vectors++;
    if (RINGING !== 1'b0) begin
      miscompares++; $display("FAIL no_early_ring: got %b want 0", RINGING);
    end
    tick(0, 5);
    vectors++;
    if (RINGING !== 1'b1) begin
      miscompares++; $display("FAIL ring_start: got %b want 1", RINGING);
    end
    tick(0, 6);
    tick(0, 7);
    vectors++;
    if (RINGING !== 1'b1) begin
      miscompares++; $display("FAIL ring_hold: got %b want 1", RINGING);
    end
    tick(0, 8);
    vectors++;
    if (RINGING !== 1'b0 || ALARM_EN !== 1'b1) begin
      miscompares++; $display("FAIL ring_timeout: got ring=%b en=%b want 0 1", RINGING, ALARM_EN);
    end
  endtask

  task automatic test_silence_priority();
    tick(0, 5);
    press(7'b1000000, 5);
    vectors++;
    if (RINGING !== 1'b0 || ALARM_EN !== 1'b1) begin
      miscompares++; $display("FAIL silence: got ring=%b en=%b want 0 1", RINGING, ALARM_EN);
    end
    press(7'b0000110, 5);
    vectors++;
    if (MODE !== 2'd1) begin
      miscompares++; $display("FAIL setc_over_seta: got %0d want 1", MODE);
    end
  endtask

  task automatic test_reset_mid();
    tick(0, 5);
    vectors++;
    if (RINGING !== 1'b1 || MODE !== 2'd1) begin
      miscompares++; $display("FAIL ring_in_setc: got ring=%b mode=%0d want 1 1", RINGING, MODE);
    end
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({MODE, EDIT_MIN, EDIT_SEC, SEL_SEC, ALARM_MIN, ALARM_SEC, ALARM_EN, RINGING, LOAD_CUR, LED_ACTIVEA}
        !== {2'd0, 7'd0, 7'd0, 1'b1, 7'd0, 7'd0, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_mid: got %h want %h",
               {MODE, EDIT_MIN, EDIT_SEC, SEL_SEC, ALARM_MIN, ALARM_SEC, ALARM_EN, RINGING, LOAD_CUR, LED_ACTIVEA},
               {2'd0, 7'd0, 7'd0, 1'b1, 7'd0, 7'd0, 4'b0000});
    end
    repeat (2) @(negedge CLK);
    model_reset();
    RST_N = 1'b1;
  endtask

  task automatic test_random();
    logic [6:0] mask;
    int hold;
    apply_reset();
    for (int it = 0; it < 160; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        if ($urandom_range(0, 2) == 0) tick(m_amin, m_asec);
        else tick(int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
      end else begin
        @(negedge CLK);
        CUR_MIN = 7'($urandom_range(0, 59));
        CUR_SEC = 7'($urandom_range(0, 59));
        if ($urandom_range(0, 9) < 7) mask = 7'b1 << $urandom_range(0, 6);
        else mask = 7'($urandom_range(1, 127));
        hold = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 7));
        press(mask, hold);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_debounce();
    test_set_current();
    test_wrap_cancel();
    test_alarm_ring();
    test_silence_priority();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/al_mode_ctrl.md
Name: al_mode_ctrl

Overview:
Central sequencer for the alarm clock. It debounces the seven user buttons and runs the VIEW/SETC/SETA mode state machine. It owns the edit registers, the stored alarm time and the alarm-enable bit, and decides when the alarm rings. It sits between the raw board buttons and the timekeeper, display and piezo blocks. It drives the timekeeper's load strobe and the display's mode and edit values.

Parameters:
DEB_CYCLES, 20000, number of consecutive stable synchronized samples required before a button level is accepted
RING_SEC, 30, number of TICK_1S pulses after which ringing stops by itself

Ports:
CLK  in  1  system clock
RST_N  in  1  reset, synchronous, active-low
BTN_VIEW  in  1  raw button: return to view mode
BTN_SETC  in  1  raw button: enter or commit current-time set mode
BTN_SETA  in  1  raw button: enter or commit alarm set mode
BTN_SECMIN  in  1  raw button: toggle between seconds and minutes field
BTN_INC  in  1  raw button: increment selected field
BTN_DEC  in  1  raw button: decrement selected field
BTN_ACTIVEA  in  1  raw button: toggle alarm enable, or silence a ringing alarm
TICK_1S  in  1  one-cycle pulse from the timekeeper, asserted on the cycle CUR_* advance
CUR_MIN  in  7  current minutes, 0..59
CUR_SEC  in  7  current seconds, 0..59
MODE  out  2  0=VIEW, 1=SETC, 2=SETA
EDIT_MIN  out  7  minutes value being edited
EDIT_SEC  out  7  seconds value being edited
SEL_SEC  out  1  1=seconds field selected, 0=minutes field selected
LOAD_CUR  out  1  one-cycle strobe; timekeeper loads EDIT_MIN/EDIT_SEC and clears its sub-second count
ALARM_MIN  out  7  stored alarm minutes
ALARM_SEC  out  7  stored alarm seconds
ALARM_EN  out  1  alarm armed
RINGING  out  1  piezo enable
LED_VIEW, LED_SETC, LED_SETA  out  1 each  one-hot decode of MODE
LED_ACTIVEA  out  1  equals ALARM_EN

Behaviour:
Reset values (RST_N=0 sampled at CLK):
- MODE=VIEW, LED_VIEW=1, LED_SETC=0, LED_SETA=0
- EDIT_MIN=0, EDIT_SEC=0, SEL_SEC=1
- ALARM_MIN=0, ALARM_SEC=0, ALARM_EN=0, RINGING=0, LOAD_CUR=0
- All debouncer states cleared to "released".

Debounce:
- Each button passes through a 2-flop synchronizer, then a stability counter.
- The accepted level changes only after DEB_CYCLES identical consecutive samples.
- A one-cycle press pulse is produced on the accepted 0->1 transition.
- Latency from a clean raw edge to the pulse is 2+DEB_CYCLES cycles.
- Releases produce no pulse, and glitches shorter than DEB_CYCLES are ignored.

Mode priority when press pulses coincide: VIEW > SETC > SETA. The lower-priority mode pulses are dropped.

Mode FSM (edit registers update on the same edge as the transition):
- VIEW + SETC press -> SETC; EDIT <= CUR_MIN/CUR_SEC; SEL_SEC <= 1.
- VIEW + SETA press -> SETA; EDIT <= ALARM_MIN/ALARM_SEC; SEL_SEC <= 1.
- SETC + SETC press -> VIEW; LOAD_CUR=1 for exactly one cycle, the cycle after the transition edge; EDIT is held stable during that cycle.
- SETA + SETA press -> VIEW; ALARM_MIN/ALARM_SEC <= EDIT on the same edge.
- SETC or SETA + VIEW press -> VIEW, edit discarded, no commit.
- SETC + SETA press -> SETA, loaded from the alarm registers; the current-time edit is discarded.
- SETA + SETC press -> SETC, loaded from CUR_*; the alarm edit is discarded.
- VIEW + VIEW press -> no change.

Field edit (SETC/SETA only; ignored in VIEW):
- SECMIN press toggles SEL_SEC.
- INC press: selected field +1, 59 wraps to 0.
- DEC press: selected field -1, 0 wraps to 59.
- INC and DEC pressed in the same cycle: no change.
- A mode press in the same cycle as INC/DEC/SECMIN takes precedence; the edit press is dropped.
- No carry between fields.

Alarm:
- ACTIVEA press while RINGING=0 toggles ALARM_EN.
- ACTIVEA press while RINGING=1 clears RINGING and leaves ALARM_EN unchanged.
- Match is evaluated on the cycle after TICK_1S: ALARM_EN=1 and CUR_MIN==ALARM_MIN and CUR_SEC==ALARM_SEC sets RINGING=1 and clears the ring counter. Ringing starts in any mode.
- While RINGING, each TICK_1S increments the ring counter; on reaching RING_SEC, RINGING clears.
- A VIEW press while ringing also clears RINGING, in addition to its mode action.
- ALARM_EN going to 0 clears RINGING.
- Committing a new alarm time while ringing does not stop ringing.

Reset asserted mid-edit or mid-ring returns all outputs to their reset values on that edge.

Decomposition:
Shared package al_ctrl_pkg holds:
- mode encoding constants MODE_VIEW=0, MODE_SETC=1, MODE_SETA=2
- the field limit value 59
- the 7-bit time field width

Sub-module al_debounce holds the synchronizer, stability counter and press-pulse logic. It is parameterized by DEB_CYCLES and instantiated once per button.

Test Plan:
All scenarios use DEB_CYCLES=4 and RING_SEC=3.
- Reset: hold RST_N=0 for 3 cycles -> MODE=0, LED_VIEW=1, SEL_SEC=1, ALARM_EN=0, RINGING=0, LOAD_CUR=0.
- Debounce: a 3-cycle BTN_INC glitch in SETC -> EDIT unchanged; a 10-cycle press -> EDIT_SEC increments exactly once, 6 cycles after the raw edge.
- Set current time:
  - Stimulus: CUR=12:58; press SETC, INC x2, SECMIN, DEC, SETC.
  - Response: EDIT passes through 12:59, 12:00, 11:00; a single LOAD_CUR pulse with EDIT=11:00; MODE returns to 0.
- Wrap and cancel: in SETA with EDIT_SEC=0, press DEC -> 59; press VIEW -> ALARM_SEC unchanged and LOAD_CUR never pulses.
- Alarm ring:
  - Stimulus: store alarm 00:05, press ACTIVEA, drive TICK_1S with CUR reaching 00:05.
  - Response: RINGING=1 the cycle after the tick; it clears after 3 further ticks; ALARM_EN stays 1.
- Silence and priority:
  - While ringing, press ACTIVEA -> RINGING=0 and ALARM_EN=1.
  - Press SETC and SETA in the same cycle from VIEW -> MODE=1.
